// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector. It compares a shift history against a latched pattern
// and produces a Mealy match strobe, a registered strobe and a saturating match counter.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               din,
    input  logic               din_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    output logic               match,
    output logic               match_q,
    output logic [CNT_W-1:0]   match_count,
    output logic [LEN_W-1:0]   fill
);

    localparam logic [LEN_W:0] MAX_LEN_X = (LEN_W+1)'(MAX_LEN);

    logic [MAX_LEN-1:0] cfg_pattern_q;
    logic [LEN_W-1:0]   cfg_len_q;
    logic               cfg_overlap_q;

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               match_q_q, match_q_d;

    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W:0]     fill_inc;
    logic               sample;
    logic               len_ok;

    always_comb begin
        cand     = {hist_q[MAX_LEN-2:0], din};
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(cfg_len_q));
        end
        fill_inc = {1'b0, fill_q} + (LEN_W+1)'(1);
        sample   = ena & din_valid & ~cfg_load;
        // Out-of-range lengths disable matching but leave the history running.
        len_ok   = (cfg_len_q != '0) && ({1'b0, cfg_len_q} <= MAX_LEN_X);

        match = sample & len_ok
              & (fill_inc >= {1'b0, cfg_len_q})
              & (((cand ^ cfg_pattern_q) & len_mask) == '0);

        hist_d    = hist_q;
        fill_d    = fill_q;
        count_d   = count_q;
        match_q_d = match_q_q;

        if (sample) begin
            hist_d = cand;
            if (match && !cfg_overlap_q) begin
                fill_d = '0;
            end else if (fill_inc >= MAX_LEN_X) begin
                fill_d = LEN_W'(MAX_LEN);
            end else begin
                fill_d = fill_inc[LEN_W-1:0];
            end
        end
        if (match && !(&count_q)) begin
            count_d = count_q + CNT_W'(1);
        end
        if (ena) begin
            match_q_d = match;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_pattern_q <= '0;
            cfg_len_q     <= '0;
            cfg_overlap_q <= 1'b0;
            hist_q        <= '0;
            fill_q        <= '0;
            count_q       <= '0;
            match_q_q     <= 1'b0;
        end else if (cfg_load) begin
            // Reconfiguration restarts detection but keeps the running match total.
            cfg_pattern_q <= pattern;
            cfg_len_q     <= pat_len;
            cfg_overlap_q <= overlap;
            hist_q        <= '0;
            fill_q        <= '0;
            match_q_q     <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            count_q   <= count_d;
            match_q_q <= match_q_d;
        end
    end

    assign match_q     = match_q_q;
    assign match_count = count_q;
    assign fill        = fill_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: pattern detection, overlap modes, gaps, saturation, resets.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               ena = 1'b0;
    logic               din = 1'b0;
    logic               din_valid = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] pattern = '0;
    logic [LEN_W-1:0]   pat_len = '0;
    logic               overlap = 1'b0;
    logic               match;
    logic               match_q;
    logic [CNT_W-1:0]   match_count;
    logic [LEN_W-1:0]   fill;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    seq_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .din_valid(din_valid),
        .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len), .overlap(overlap),
        .match(match), .match_q(match_q), .match_count(match_count), .fill(fill)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; m/mq are observed before the rising edge consumes the inputs.
    task automatic step(input logic b, input logic v, input logic e, output logic m, output logic mq);
        @(negedge clk);
        cfg_load  = 1'b0;
        din       = b;
        din_valid = v;
        ena       = e;
        #1;
        m  = match;
        mq = match_q;
    endtask

    // Loads a configuration with din_valid high; returns match seen during the load cycle and fill after it.
    task automatic do_cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic ov,
                          output logic m, output logic [LEN_W-1:0] f);
        @(negedge clk);
        cfg_load  = 1'b1;
        pattern   = p;
        pat_len   = l;
        overlap   = ov;
        ena       = 1'b1;
        din       = 1'b1;
        din_valid = 1'b1;
        #1;
        m = match;
        @(posedge clk);
        #1;
        f = fill;
        pattern = ~p;
        pat_len = '0;
        overlap = ~ov;
    endtask

    task automatic test_reset();
        @(negedge clk);
        ena = 1'b1; din = 1'b1; din_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL reset_match got %0b exp 0", match); end
        checks++; if (match_q !== 1'b0) begin errors++; $display("FAIL reset_match_q got %0b exp 0", match_q); end
        checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", match_count); end
        checks++; if (fill !== 4'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", fill); end
        @(negedge clk);
        din_valid = 1'b0;
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic run_11011(input logic ov);
        logic [10:0] bits;
        logic [10:0] exp_m;
        logic m, mq, prev, cm;
        logic [LEN_W-1:0] f;
        bits  = 11'b110_1101_1011;
        exp_m = ov ? 11'b100_1001_0000 : 11'b100_0001_0000;
        do_cfg(8'b0001_1011, 4'd5, ov, cm, f);
        checks++; if (cm !== 1'b0) begin errors++; $display("FAIL cfg_cycle_match ov=%0b got %0b exp 0", ov, cm); end
        checks++; if (f !== 4'd0) begin errors++; $display("FAIL cfg_cycle_fill ov=%0b got %0d exp 0", ov, f); end
        prev = 1'b0;
        for (int i = 0; i < 11; i++) begin
            step(bits[10-i], 1'b1, 1'b1, m, mq);
            checks++; if (m !== exp_m[i]) begin errors++; $display("FAIL match_11011 ov=%0b idx=%0d got %0b exp %0b", ov, i, m, exp_m[i]); end
            checks++; if (mq !== prev) begin errors++; $display("FAIL match_q_11011 ov=%0b idx=%0d got %0b exp %0b", ov, i, mq, prev); end
            prev = exp_m[i];
            if (exp_m[i]) exp_cnt++;
        end
        step(1'b0, 1'b0, 1'b1, m, mq);
        checks++; if (mq !== 1'b1) begin errors++; $display("FAIL match_q_last ov=%0b got %0b exp 1", ov, mq); end
        checks++; if (match_count !== 8'(exp_cnt)) begin errors++; $display("FAIL count_11011 ov=%0b got %0d exp %0d", ov, match_count, exp_cnt); end
        checks++; if (fill !== (ov ? 4'd8 : 4'd0)) begin errors++; $display("FAIL fill_11011 ov=%0b got %0d exp %0d", ov, fill, ov ? 8 : 0); end
    endtask

    task automatic test_nonoverlap();
        run_11011(1'b0);
    endtask

    task automatic test_overlap();
        run_11011(1'b1);
    endtask

    task automatic test_gaps();
        logic m, mq, cm;
        logic [LEN_W-1:0] f;
        do_cfg(8'b0000_0101, 4'd3, 1'b0, cm, f);
        step(1'b1, 1'b1, 1'b1, m, mq);
        checks++; if (m !== 1'b0) begin errors++; $display("FAIL gap_bit0 got %0b exp 0", m); end
        step(1'b0, 1'b0, 1'b1, m, mq);
        checks++; if (m !== 1'b0) begin errors++; $display("FAIL gap_invalid got %0b exp 0", m); end
        checks++; if (fill !== 4'd1) begin errors++; $display("FAIL gap_fill_hold got %0d exp 1", fill); end
        step(1'b0, 1'b1, 1'b1, m, mq);
        checks++; if (m !== 1'b0) begin errors++; $display("FAIL gap_bit1 got %0b exp 0", m); end
        step(1'b1, 1'b1, 1'b0, m, mq);
        checks++; if (m !== 1'b0) begin errors++; $display("FAIL gap_ena_low got %0b exp 0", m); end
        checks++; if (fill !== 4'd2) begin errors++; $display("FAIL gap_ena_fill got %0d exp 2", fill); end
        step(1'b1, 1'b1, 1'b1, m, mq);
        checks++; if (m !== 1'b1) begin errors++; $display("FAIL gap_bit2 got %0b exp 1", m); end
        exp_cnt++;
        step(1'b0, 1'b1, 1'b0, m, mq);
        checks++; if (mq !== 1'b1) begin errors++; $display("FAIL gap_mq_after got %0b exp 1", mq); end
        step(1'b0, 1'b0, 1'b1, m, mq);
        checks++; if (mq !== 1'b1) begin errors++; $display("FAIL gap_mq_hold got %0b exp 1", mq); end
        step(1'b0, 1'b0, 1'b1, m, mq);
        checks++; if (mq !== 1'b0) begin errors++; $display("FAIL gap_mq_clear got %0b exp 0", mq); end
        checks++; if (match_count !== 8'(exp_cnt)) begin errors++; $display("FAIL gap_count got %0d exp %0d", match_count, exp_cnt); end
    endtask

    task automatic test_saturate();
        logic m, mq, cm;
        logic [LEN_W-1:0] f;
        int bad;
        bad = 0;
        do_cfg(8'b0000_0001, 4'd1, 1'b0, cm, f);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b1, 1'b1, m, mq);
            if (m !== 1'b1) bad++;
            if (exp_cnt < 255) exp_cnt++;
            if (exp_cnt == 254) begin
                @(posedge clk); #1;
                checks++; if (match_count !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d exp 254", match_count); end
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL sat_match_each got %0d misses exp 0", bad); end
        step(1'b0, 1'b0, 1'b1, m, mq);
        checks++; if (match_count !== 8'd255) begin errors++; $display("FAIL sat_count got %0d exp 255", match_count); end
    endtask

    task automatic test_async_reset();
        logic m, mq;
        logic [3:0] bits;
        bits = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            step(bits[3-i], 1'b1, 1'b1, m, mq);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL async_count got %0d exp 0", match_count); end
        checks++; if (fill !== 4'd0) begin errors++; $display("FAIL async_fill got %0d exp 0", fill); end
        #1 rst_n = 1'b1;
        exp_cnt = 0;
        step(1'b1, 1'b1, 1'b1, m, mq);
        checks++; if (m !== 1'b0) begin errors++; $display("FAIL async_after_match got %0b exp 0", m); end
        step(1'b0, 1'b0, 1'b1, m, mq);
        checks++; if (fill !== 4'd1) begin errors++; $display("FAIL async_after_fill got %0d exp 1", fill); end
        checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL async_after_count got %0d exp 0", match_count); end
    endtask

    task automatic test_len_disabled();
        logic m, mq, cm;
        logic [LEN_W-1:0] f;
        int hits;
        hits = 0;
        do_cfg(8'hFF, 4'd0, 1'b1, cm, f);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b1, m, mq);
            if (m !== 1'b0) hits++;
        end
        do_cfg(8'hFF, 4'd9, 1'b1, cm, f);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b1, m, mq);
            if (m !== 1'b0) hits++;
        end
        checks++; if (hits != 0) begin errors++; $display("FAIL len_disabled_hits got %0d exp 0", hits); end
        step(1'b0, 1'b0, 1'b1, m, mq);
        checks++; if (fill !== 4'd8) begin errors++; $display("FAIL len_disabled_fill got %0d exp 8", fill); end
        checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL len_disabled_count got %0d exp 0", match_count); end
    endtask

    task automatic test_max_len();
        logic m, mq, cm;
        logic [LEN_W-1:0] f;
        logic [7:0] bits;
        bits = 8'hA5;
        for (int i = 0; i < 7; i++) begin
            step(bits[7-i], 1'b1, 1'b1, m, mq);
        end
        do_cfg(8'hA5, 4'd8, 1'b0, cm, f);
        checks++; if (f !== 4'd0) begin errors++; $display("FAIL maxlen_cfg_fill got %0d exp 0", f); end
        for (int i = 0; i < 8; i++) begin
            step(bits[7-i], 1'b1, 1'b1, m, mq);
            checks++; if (m !== (i == 7)) begin errors++; $display("FAIL maxlen_match idx=%0d got %0b exp %0b", i, m, i == 7); end
        end
        exp_cnt++;
        step(1'b0, 1'b0, 1'b1, m, mq);
        checks++; if (match_count !== 8'(exp_cnt)) begin errors++; $display("FAIL maxlen_count got %0d exp %0d", match_count, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_nonoverlap();
        test_overlap();
        test_gaps();
        test_saturate();
        test_async_reset();
        test_len_disabled();
        test_max_len();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
